// File: rtl/alsu_pipe.sv
// alsu_pipe: two-stage pipelined arithmetic/logic/shift unit with error tracking.
// Define ALSU_PIPE_FULL_ADDER_EN to make opcode 2 add the carry-in.
module alsu_pipe #(
   parameter int WIDTH = 8,
   parameter INPUT_PRIORITY = "A",
   parameter int LED_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 in_valid,
   input  logic [WIDTH-1:0]     A,
   input  logic [WIDTH-1:0]     B,
   input  logic                 cin,
   input  logic                 serial_in,
   input  logic                 direction,
   input  logic                 red_op_A,
   input  logic                 red_op_B,
   input  logic                 bypass_A,
   input  logic                 bypass_B,
   input  logic [2:0]           opcode,
   output logic [2*WIDTH-1:0]   out,
   output logic                 out_valid,
   output logic [LED_WIDTH-1:0] leds,
   output logic [7:0]           err_cnt
);
   localparam int OW = 2*WIDTH;
   localparam bit PRI_B = (INPUT_PRIORITY == "B");
   logic [WIDTH-1:0] a_r, b_r, red_src;
   logic cin_r, ser_r, dir_r, ra_r, rb_r, ba_r, bb_r, v1;
   logic [2:0] op_r;
   logic [OW-1:0] a_x, b_x, prod, nxt;
   logic inv, byp_b, red_b, red_bit, cin_add;
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         {a_r, b_r, cin_r, ser_r, dir_r, ra_r, rb_r, ba_r, bb_r, op_r, v1} <= '0;
      end else begin
         v1 <= in_valid;
         if (in_valid) begin
            a_r   <= A;
            b_r   <= B;
            cin_r <= cin;
            ser_r <= serial_in;
            dir_r <= direction;
            ra_r  <= red_op_A;
            rb_r  <= red_op_B;
            ba_r  <= bypass_A;
            bb_r  <= bypass_B;
            op_r  <= opcode;
         end
      end
`ifdef ALSU_PIPE_FULL_ADDER_EN
   assign cin_add = cin_r;
`else
   // carry-in is captured but deliberately has no effect in this build
   assign cin_add = 1'b0 & cin_r;
`endif
   always_comb begin
      a_x     = {{WIDTH{a_r[WIDTH-1]}}, a_r};
      b_x     = {{WIDTH{b_r[WIDTH-1]}}, b_r};
      inv     = ((ra_r | rb_r) && op_r[2:1] != 2'b00) || op_r[2:1] == 2'b11;
      byp_b   = bb_r && (!ba_r || PRI_B);
      red_b   = rb_r && (!ra_r || PRI_B);
      red_src = red_b ? b_r : a_r;
      red_bit = op_r[0] ? ^red_src : |red_src;
      prod    = $signed(a_r) * $signed(b_r);
      // shift/rotate read the live stage-2 register, so back-to-back ops chain naturally
      nxt = inv ? '0 :
            (ba_r | bb_r) ? (byp_b ? b_x : a_x) :
            (op_r[2:1] == 2'b00) ? ((ra_r | rb_r) ? {{(OW-1){1'b0}}, red_bit} :
                                    {{WIDTH{1'b0}}, op_r[0] ? (a_r ^ b_r) : (a_r | b_r)}) :
            (op_r == 3'd2) ? a_x + b_x + {{(OW-1){1'b0}}, cin_add} :
            (op_r == 3'd3) ? prod :
            (op_r == 3'd4) ? (dir_r ? {out[OW-2:0], ser_r} : {ser_r, out[OW-1:1]}) :
            (dir_r ? {out[OW-2:0], out[OW-1]} : {out[0], out[OW-1:1]});
   end
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         out       <= '0;
         out_valid <= 1'b0;
         leds      <= '0;
         err_cnt   <= '0;
      end else begin
         out_valid <= v1;
         if (v1) begin
            out     <= nxt;
            leds    <= inv ? ~leds : '0;
            err_cnt <= (inv && err_cnt != 8'hFF) ? err_cnt + 8'd1 : err_cnt;
         end
      end
endmodule
